// File: rtl/pen_locator_if.sv
// rtl/pen_locator_if.sv - located pen position stream (valid/ready)
interface pen_locator_if;
  logic       hit_valid;
  logic       hit_ready;
  logic [2:0] hit_row;
  logic [2:0] hit_col;

  modport master (output hit_valid, output hit_row, output hit_col, input hit_ready);
  modport slave  (input hit_valid, input hit_row, input hit_col, output hit_ready);
endinterface

// File: rtl/pen_locator.sv
// rtl/pen_locator.sv - light-pen probe scan decoder; optional PEN_FILTER_EN
module pen_locator #(
  parameter int SETTLE_CYC  = 4,
  parameter int THRESH      = 8,
  parameter int CNT_W       = 8,
  parameter int LOST_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 probe_active,
  input  logic                 pix_start,
  input  logic [2:0]           pix_row,
  input  logic [2:0]           pix_col,
  input  logic                 frame_end,
  input  logic                 pen_in,
  pen_locator_if.master        hit,
  output logic                 hit_overflow,
  input  logic                 clr_ovf,
  output logic                 pen_lost
);

  localparam int PH_W   = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOST_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  THR = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t            state_q, state_d;
  logic              pen_meta, pen_s;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  cnt, best_cnt, nb_cnt;
  logic [2:0]        cur_row, cur_col, best_row, best_col, nb_row, nb_col;
  logic [MISS_W-1:0] miss, miss_d;
  logic              abort, start, resolve, eval, qual, nb_present, report, load_ok;

  // Bring the asynchronous pen detect into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_meta <= 1'b0;
      pen_s    <= 1'b0;
    end else begin
      pen_meta <= pen_in;
      pen_s    <= pen_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes; abort beats frame_end beats pix_start
  always_comb begin
    state_d = state_q;
    abort   = !probe_active;
    resolve = probe_active && frame_end;
    start   = probe_active && pix_start && !frame_end;
    eval    = (state_q != IDLE) && (resolve || start);
    if (abort || resolve)                              state_d = IDLE;
    else if (start)                                    state_d = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
    else if (state_q == SETTLE && phase == PH_LAST)    state_d = SAMPLE;
  end

  // Candidate best including the pixel being evaluated this cycle
  always_comb begin
    qual       = eval && (cnt >= THR) && (cnt > best_cnt);
    nb_row     = qual ? cur_row : best_row;
    nb_col     = qual ? cur_col : best_col;
    nb_cnt     = qual ? cnt     : best_cnt;
    nb_present = (nb_cnt != '0);
    load_ok    = !hit.hit_valid || hit.hit_ready;
    miss_d     = miss;
    if (resolve) begin
      if (nb_present)            miss_d = '0;
      else if (miss != MISS_MAX) miss_d = miss + 1'b1;
    end
  end

`ifdef PEN_FILTER_EN
  logic       prev_vld;
  logic [2:0] prev_row, prev_col;

  // Previous frame's raw best, used to reject single-frame glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      prev_row <= '0;
      prev_col <= '0;
    end else if (resolve) begin
      prev_vld <= nb_present;
      prev_row <= nb_row;
      prev_col <= nb_col;
    end
  end

  // Report only a position confirmed by two consecutive frames
  always_comb begin
    report = nb_present && prev_vld && (prev_row == nb_row) && (prev_col == nb_col);
  end
`else
  // Every frame's best is reported
  always_comb begin
    report = nb_present;
  end
`endif

  // Per-pixel phase/sample counters and latched pixel address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      cnt     <= '0;
      cur_row <= '0;
      cur_col <= '0;
    end else if (start) begin
      phase   <= '0;
      cnt     <= '0;
      cur_row <= pix_row;
      cur_col <= pix_col;
    end else begin
      if (state_q == SETTLE) phase <= phase + 1'b1;
      if (state_q == SAMPLE && pen_s && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // Running best of the frame; cleared on abort and at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_row <= '0;
      best_col <= '0;
      best_cnt <= '0;
    end else if (abort || resolve) begin
      best_row <= '0;
      best_col <= '0;
      best_cnt <= '0;
    end else if (qual) begin
      best_row <= cur_row;
      best_col <= cur_col;
      best_cnt <= cnt;
    end
  end

  // Output stream, sticky overflow and pen-lost tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit.hit_valid <= 1'b0;
      hit.hit_row   <= '0;
      hit.hit_col   <= '0;
      hit_overflow  <= 1'b0;
      miss          <= MISS_MAX;
      pen_lost      <= 1'b1;
    end else begin
      if (resolve && report && load_ok) begin
        hit.hit_valid <= 1'b1;
        hit.hit_row   <= nb_row;
        hit.hit_col   <= nb_col;
      end else if (hit.hit_valid && hit.hit_ready) begin
        hit.hit_valid <= 1'b0;
      end
      if (resolve && report && !load_ok) hit_overflow <= 1'b1;
      else if (clr_ovf)                  hit_overflow <= 1'b0;
      miss     <= miss_d;
      pen_lost <= (miss_d == MISS_MAX);
    end
  end

endmodule
